// File: rtl/store_buffer_if.sv
// store_buffer_if: LSU-side store/load request bus plus the drain port toward data_memory.
// master = LSU / core side, slave = store buffer.
interface store_buffer_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [1:0]        st_size;
    logic [XLEN-1:0]   st_data;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_size;
    logic              ld_stall;
    logic              ld_fwd_hit;
    logic [XLEN-1:0]   ld_fwd_data;
    logic              drain_req;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_store_size;
    logic [XLEN-1:0]   mem_write_data;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport master (
        output st_valid, st_addr, st_size, st_data,
        output ld_valid, ld_addr, ld_size, drain_req,
        input  st_ready, ld_stall, ld_fwd_hit, ld_fwd_data,
        input  mem_write_en, mem_addr, mem_store_size, mem_write_data,
        input  count, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_size, st_data,
        input  ld_valid, ld_addr, ld_size, drain_req,
        output st_ready, ld_stall, ld_fwd_hit, ld_fwd_data,
        output mem_write_en, mem_addr, mem_store_size, mem_write_data,
        output count, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: post-commit store FIFO between the LSU and data_memory.
// Retired stores queue in order and drain to the single memory port whenever
// no load owns it. Younger loads are checked against queued stores.
// Optional feature macro: STORE_BUF_FWD_EN (store-to-load forwarding).
// Without it any word-address match simply stalls the load.
// store_buffer_chk holds the single-issue property for binding/instantiation
// next to the buffer.
module store_buffer #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave bus
);
    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ent_addr_r [DEPTH];
    logic [1:0]        ent_size_r [DEPTH];
    logic [XLEN-1:0]   ent_data_r [DEPTH];
    logic [DEPTH-1:0]  ent_valid_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              run_r;

    logic              empty_s;
    logic              full_s;
    logic              st_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              match_any_s;
    logic [PTR_W-1:0]  match_idx_s;
    logic              ld_stall_s;
    logic              fwd_hit_s;
    logic [XLEN-1:0]   fwd_data_s;

    assign empty_s    = (cnt_r == {CNT_W{1'b0}});
    assign full_s     = (cnt_r == CNT_W'(DEPTH));
    // run_r keeps st_ready low while reset is applied and for the first edge after it.
    assign st_ready_s = run_r && !full_s && !bus.drain_req;
    assign push_s     = bus.st_valid && st_ready_s;
    // A stalled load cannot use the port, so the head drains; otherwise it would deadlock.
    assign pop_s      = !empty_s && (!bus.ld_valid || ld_stall_s);

    // Scan queued entries oldest to youngest so the last word match is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        logic             hit_v;
        match_any_s = 1'b0;
        match_idx_s = {PTR_W{1'b0}};
        idx_v       = {PTR_W{1'b0}};
        hit_v       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_v       = rd_ptr_r + PTR_W'(i);
            hit_v       = ent_valid_r[idx_v] &&
                          (ent_addr_r[idx_v][ADDR_W-1:OFF_W] == bus.ld_addr[ADDR_W-1:OFF_W]);
            match_any_s = match_any_s | hit_v;
            match_idx_s = hit_v ? idx_v : match_idx_s;
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic [LANES-1:0] ent_mask_r [DEPTH];

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size,
                                                   input logic [OFF_W-1:0] off);
        logic [LANES-1:0] base;
        case (size)
            2'b00:   base = {{(LANES-1){1'b0}}, 1'b1};
            2'b01:   base = {{(LANES-2){1'b0}}, 2'b11};
            default: base = {LANES{1'b1}};
        endcase
        return base << off;
    endfunction

    // Byte-lane mask per entry, captured alongside the store on push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_mask_r[i] <= {LANES{1'b0}};
            end
        end else if (push_s) begin
            ent_mask_r[wr_ptr_r] <= lane_mask(bus.st_size, bus.st_addr[OFF_W-1:0]);
        end
    end

    // Forward when the youngest match covers every load byte, otherwise hold the load.
    always_comb begin
        logic [LANES-1:0] ld_mask_v;
        logic [LANES-1:0] ent_mask_v;
        logic [XLEN-1:0]  shifted_v;
        logic             covered_v;
        ld_mask_v  = lane_mask(bus.ld_size, bus.ld_addr[OFF_W-1:0]);
        ent_mask_v = ent_mask_r[match_idx_s];
        covered_v  = ((ld_mask_v & ~ent_mask_v) == {LANES{1'b0}});
        shifted_v  = ent_data_r[match_idx_s] << {ent_addr_r[match_idx_s][OFF_W-1:0], 3'b000};
        ld_stall_s = bus.ld_valid && match_any_s && !covered_v;
        fwd_hit_s  = bus.ld_valid && match_any_s && covered_v;
        fwd_data_s = {XLEN{1'b0}};
        for (int b = 0; b < LANES; b++) begin
            fwd_data_s[8*b +: 8] = (fwd_hit_s && ent_mask_v[b]) ? shifted_v[8*b +: 8] : 8'h00;
        end
    end
`else
    // Without forwarding, any word overlap holds the load until the entry has drained.
    always_comb begin
        ld_stall_s = bus.ld_valid && match_any_s;
        fwd_hit_s  = 1'b0;
        fwd_data_s = {XLEN{1'b0}};
    end

    logic unused_ld_lanes;
    assign unused_ld_lanes = ^{bus.ld_size, bus.ld_addr[OFF_W-1:0]};
`endif

    // Queue state: push at the tail, pop at the head, count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_r[i] <= {ADDR_W{1'b0}};
                ent_size_r[i] <= 2'b00;
                ent_data_r[i] <= {XLEN{1'b0}};
            end
            ent_valid_r <= {DEPTH{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            run_r       <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (push_s) begin
                ent_addr_r[wr_ptr_r]  <= bus.st_addr;
                ent_size_r[wr_ptr_r]  <= bus.st_size;
                ent_data_r[wr_ptr_r]  <= bus.st_data;
                ent_valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                ent_valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r              <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign bus.st_ready       = st_ready_s;
    assign bus.ld_stall       = ld_stall_s;
    assign bus.ld_fwd_hit     = fwd_hit_s;
    assign bus.ld_fwd_data    = fwd_data_s;
    assign bus.mem_write_en   = pop_s;
    assign bus.mem_addr       = pop_s ? ent_addr_r[rd_ptr_r] : {ADDR_W{1'b0}};
    assign bus.mem_store_size = pop_s ? ent_size_r[rd_ptr_r] : 2'b00;
    assign bus.mem_write_data = pop_s ? ent_data_r[rd_ptr_r] : {XLEN{1'b0}};
    assign bus.count          = cnt_r;
    assign bus.empty          = empty_s;
    assign bus.full           = full_s;
endmodule

// store_buffer_chk: the LSU is single-issue, so a store and a load never share a cycle.
// en lets an environment that models port contention with ld_valid switch the check off.
module store_buffer_chk (
    input logic clk,
    input logic rst,
    input logic en,
    input logic st_valid,
    input logic ld_valid
);
    single_issue_a: assert property (@(posedge clk) disable iff (!rst || !en)
                                     !(st_valid && ld_valid))
        else $error("store_buffer: st_valid and ld_valid asserted together");
endmodule
